// File: rtl/rect_draw_sched.sv
// Round-robin rectangle-draw scheduler: grants one requester at a time and scans
// its rectangle row-major onto the single VGA pixel port. Optional: RECT_OUTLINE_EN.
module rect_draw_sched #(
  parameter int NUM_REQ  = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*X_W-1:0]       req_w,
  input  logic [NUM_REQ*Y_W-1:0]       req_h,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
`ifdef RECT_OUTLINE_EN
  input  logic [NUM_REQ-1:0]           req_outline,
`endif
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic                         plot,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     ptr_q, sel_q;
  logic [NUM_REQ-1:0]   gnt_q, done_q;
  logic                 busy_q, plot_q;
  logic [X_W-1:0]       vx_q, x_q, w_q, dx_q;
  logic [Y_W-1:0]       vy_q, y_q, h_q, dy_q;
  logic [COLOUR_W-1:0]  vc_q, col_q;
  logic                 outl_q;

  // Unpacked per-requester views of the packed command buses
  logic [X_W-1:0]      rx [NUM_REQ];
  logic [Y_W-1:0]      ry [NUM_REQ];
  logic [X_W-1:0]      rw [NUM_REQ];
  logic [Y_W-1:0]      rh [NUM_REQ];
  logic [COLOUR_W-1:0] rc [NUM_REQ];
  logic [NUM_REQ-1:0]  ro;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rx[i] = req_x[i*X_W +: X_W];
    assign ry[i] = req_y[i*Y_W +: Y_W];
    assign rw[i] = req_w[i*X_W +: X_W];
    assign rh[i] = req_h[i*Y_W +: Y_W];
    assign rc[i] = req_colour[i*COLOUR_W +: COLOUR_W];
`ifdef RECT_OUTLINE_EN
    assign ro[i] = req_outline[i];
`else
    assign ro[i] = 1'b0;
`endif
  end

  // Round-robin pick: descending scan so the smallest offset from ptr wins
  logic             pick_vld;
  logic [IDX_W-1:0] pick, cand;

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int off = NUM_REQ-1; off >= 0; off--) begin
      cand = IDX_W'((int'(ptr_q) + off) % NUM_REQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Next pixel to present: first pixel when leaving LATCH, else the scan successor
  logic [X_W-1:0]  bx, bw, ndx;
  logic [Y_W-1:0]  by, bh, ndy;
  logic            bo, last, interior, on_scr, pix_on;
  logic [X_W:0]    px;
  logic [Y_W:0]    py;

  always_comb begin
    bx   = (state_q == LATCH) ? rx[sel_q] : x_q;
    by   = (state_q == LATCH) ? ry[sel_q] : y_q;
    bw   = (state_q == LATCH) ? rw[sel_q] : w_q;
    bh   = (state_q == LATCH) ? rh[sel_q] : h_q;
    bo   = (state_q == LATCH) ? ro[sel_q] : outl_q;
    ndx  = '0;
    ndy  = '0;
    last = 1'b0;
    if (state_q == DRAW) begin
      last = (dx_q == w_q - X_W'(1)) && (dy_q == h_q - Y_W'(1));
      if (dx_q == w_q - X_W'(1)) begin
        ndx = '0;
        ndy = dy_q + Y_W'(1);
      end else begin
        ndx = dx_q + X_W'(1);
        ndy = dy_q;
      end
    end
    // One extra bit so coordinates past the field range clip instead of wrapping
    px       = {1'b0, bx} + {1'b0, ndx};
    py       = {1'b0, by} + {1'b0, ndy};
    on_scr   = (px < SCR_W) && (py < SCR_H);
    interior = (ndx != '0) && (ndx != bw - X_W'(1)) &&
               (ndy != '0) && (ndy != bh - Y_W'(1));
    pix_on   = on_scr && !(bo && interior);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      plot_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      outl_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            sel_q   <= pick;
            gnt_q   <= NUM_REQ'(1) << pick;
            busy_q  <= 1'b1;
            state_q <= LATCH;
          end
        end
        LATCH: begin
          x_q    <= rx[sel_q];
          y_q    <= ry[sel_q];
          w_q    <= rw[sel_q];
          h_q    <= rh[sel_q];
          col_q  <= rc[sel_q];
          outl_q <= ro[sel_q];
          dx_q   <= '0;
          dy_q   <= '0;
          if (rw[sel_q] == '0 || rh[sel_q] == '0) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= DONE;
          end else begin
            plot_q  <= pix_on;
            vx_q    <= px[X_W-1:0];
            vy_q    <= py[Y_W-1:0];
            vc_q    <= rc[sel_q];
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (last) begin
            plot_q  <= 1'b0;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= DONE;
          end else begin
            dx_q   <= ndx;
            dy_q   <= ndy;
            plot_q <= pix_on;
            vx_q   <= px[X_W-1:0];
            vy_q   <= py[Y_W-1:0];
            vc_q   <= col_q;
          end
        end
        DONE: begin
          // Served requester drops to lowest priority for the next round
          ptr_q   <= (sel_q == IDX_W'(NUM_REQ-1)) ? '0 : sel_q + IDX_W'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign plot       = plot_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;

endmodule
